cpu_ctrl_fsm: RTL and testbench

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

---
 rtl/cpu_ctrl_fsm.sv | 203 ++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control sequencer for a small accumulator CPU.
// It walks FETCH/DECODE/OPFETCH/EXEC/MEM and decodes the datapath strobes
// combinationally from the current state and the live datapath inputs.
// A wait counter turns a stalled memory access into a FAULT.
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous active-low reset (forces IDLE)
//   instr      in   [7:0] instruction register, opcode = instr[7:4]
//   zero_flag  in   accumulator-zero flag
//   mem_ready  in   memory completes the current access this cycle
//   run        in   resume request while halted
//   mem_req    out  memory access request
//   mem_we     out  memory write enable (STA in MEM)
//   mem_sel_pc out  address source: 1 = PC, 0 = operand register
//   ir_load    out  load instruction register
//   opr_load   out  load operand register
//   pc_inc     out  increment PC
//   pc_load    out  load PC from operand register
//   acc_load   out  load accumulator from ALU result
//   alu_op     out  [2:0] 000 PASS, 001 ADD, 010 SUB
//   halted     out  high in HALT
//   fault      out  high in FAULT
//   state      out  [2:0] current state encoding
module cpu_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr,
  input  logic       zero_flag,
  input  logic       mem_ready,
  input  logic       run,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel_pc,
  output logic       ir_load,
  output logic       opr_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_load,
  output logic [2:0] alu_op,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPFETCH = 3'd2,
    S_EXEC    = 3'd3,
    S_MEM     = 3'd4,
    S_HALT    = 3'd5,
    S_FAULT   = 3'd6,
    S_IDLE    = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_next;
  logic [3:0]       w_opcode;
  logic             w_timeout;

  assign w_opcode  = instr[7:4];
  assign w_timeout = (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign state     = r_state;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
    end
  end

  // Next-state and strobe decode. The counter only keeps counting while a
  // memory state is stalled in place, so every entry into one starts at 0.
  always_comb begin
    w_next      = r_state;
    w_wait_next = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_sel_pc  = 1'b0;
    ir_load     = 1'b0;
    opr_load    = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    acc_load    = 1'b0;
    alu_op      = 3'b000;
    halted      = 1'b0;
    fault       = 1'b0;

    case (r_state)
      S_IDLE: w_next = S_FETCH;

      S_FETCH: begin
        mem_req    = 1'b1;
        mem_sel_pc = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          w_next  = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end else begin
          w_wait_next = r_wait_cnt + CNT_W'(1);
        end
      end

      S_DECODE: begin
        case (w_opcode)
          OP_NOP:                                       w_next = S_FETCH;
          OP_HLT:                                       w_next = S_HALT;
          OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_JMP, OP_JZ: w_next = S_OPFETCH;
          default:                                      w_next = S_FAULT;
        endcase
      end

      S_OPFETCH: begin
        mem_req    = 1'b1;
        mem_sel_pc = 1'b1;
        if (mem_ready) begin
          opr_load = 1'b1;
          pc_inc   = 1'b1;
          w_next   = S_EXEC;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end else begin
          w_wait_next = r_wait_cnt + CNT_W'(1);
        end
      end

      S_EXEC: begin
        case (w_opcode)
          OP_JMP: begin
            pc_load = 1'b1;
            w_next  = S_FETCH;
          end
          OP_JZ: begin
            pc_load = zero_flag;
            w_next  = S_FETCH;
          end
          OP_LDA, OP_STA, OP_ADD, OP_SUB: w_next = S_MEM;
          // instr changed under us after DECODE: treat as illegal
          default: w_next = S_FAULT;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (w_opcode == OP_STA);
        if (mem_ready) begin
          case (w_opcode)
            OP_LDA: begin
              acc_load = 1'b1;
              alu_op   = 3'b000;
            end
            OP_ADD: begin
              acc_load = 1'b1;
              alu_op   = 3'b001;
            end
            OP_SUB: begin
              acc_load = 1'b1;
              alu_op   = 3'b010;
            end
            default: acc_load = 1'b0;
          endcase
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end else begin
          w_wait_next = r_wait_cnt + CNT_W'(1);
        end
      end

      S_HALT: begin
        halted = 1'b1;
        if (run) w_next = S_FETCH;
      end

      S_FAULT: fault = 1'b1;

      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: the stimulus process drives one cycle
// of inputs just after each rising edge and queues the hand-computed output
// vector for that cycle; the monitor pops and compares on the falling edge.
module tb_cpu_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic [7:0] instr;
  logic       zero_flag;
  logic       mem_ready;
  logic       run;
  logic       mem_req;
  logic       mem_we;
  logic       mem_sel_pc;
  logic       ir_load;
  logic       opr_load;
  logic       pc_inc;
  logic       pc_load;
  logic       acc_load;
  logic [2:0] alu_op;
  logic       halted;
  logic       fault;
  logic [2:0] state;

  cpu_ctrl_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .zero_flag (zero_flag),
    .mem_ready (mem_ready),
    .run       (run),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_sel_pc(mem_sel_pc),
    .ir_load   (ir_load),
    .opr_load  (opr_load),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .acc_load  (acc_load),
    .alu_op    (alu_op),
    .halted    (halted),
    .fault     (fault),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe bit positions in the expected vector.
  localparam logic [9:0] MR = 10'd1;    // mem_req
  localparam logic [9:0] WE = 10'd2;    // mem_we
  localparam logic [9:0] SP = 10'd4;    // mem_sel_pc
  localparam logic [9:0] IR = 10'd8;    // ir_load
  localparam logic [9:0] OR = 10'd16;   // opr_load
  localparam logic [9:0] PI = 10'd32;   // pc_inc
  localparam logic [9:0] PL = 10'd64;   // pc_load
  localparam logic [9:0] AL = 10'd128;  // acc_load
  localparam logic [9:0] HL = 10'd256;  // halted
  localparam logic [9:0] FT = 10'd512;  // fault

  localparam logic [9:0] FETCH_OK = MR | SP | IR | PI;
  localparam logic [9:0] FETCH_WT = MR | SP;
  localparam logic [9:0] OPF_OK   = MR | SP | OR | PI;

  typedef struct {
    logic [15:0] v;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  // One cycle of stimulus plus its expected outputs.
  task automatic cyc(input logic rst, input logic [7:0] ins, input logic zf,
                     input logic mr, input logic rn, input logic [2:0] st,
                     input logic [9:0] strb, input logic [2:0] alu);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    instr     = ins;
    zero_flag = zf;
    mem_ready = mr;
    run       = rn;
    step++;
    e.v  = {st, alu, strb};
    e.id = step;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the full output vector each cycle an expectation exists.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {state, alu_op, fault, halted, acc_load, pc_load, pc_inc,
             opr_load, ir_load, mem_sel_pc, mem_we, mem_req};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL cycle%0d: got state=%0d alu=%b strb=%b, want state=%0d alu=%b strb=%b",
                 e.id, act[15:13], act[12:10], act[9:0], e.v[15:13], e.v[12:10], e.v[9:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    instr     = 8'h00;
    zero_flag = 1'b0;
    mem_ready = 1'b1;
    run       = 1'b0;

    // Reset and NOP stream: 7,7,0,1,0,1
    cyc(0, 8'h00, 0, 1, 0, 3'd7, 10'd0, 3'b000);
    cyc(1, 8'h00, 0, 1, 0, 3'd7, 10'd0, 3'b000);
    cyc(1, 8'h00, 0, 1, 0, 3'd0, FETCH_OK, 3'b000);
    cyc(1, 8'h00, 0, 1, 0, 3'd1, 10'd0, 3'b000);
    cyc(1, 8'h00, 0, 1, 0, 3'd0, FETCH_OK, 3'b000);
    cyc(1, 8'h00, 0, 1, 0, 3'd1, 10'd0, 3'b000);

    // LDA
    cyc(1, 8'h13, 0, 1, 0, 3'd0, FETCH_OK, 3'b000);
    cyc(1, 8'h13, 0, 1, 0, 3'd1, 10'd0, 3'b000);
    cyc(1, 8'h13, 0, 1, 0, 3'd2, OPF_OK, 3'b000);
    cyc(1, 8'h13, 0, 1, 0, 3'd3, 10'd0, 3'b000);
    cyc(1, 8'h13, 0, 1, 0, 3'd4, MR | AL, 3'b000);

    // STA
    cyc(1, 8'h25, 0, 1, 0, 3'd0, FETCH_OK, 3'b000);
    cyc(1, 8'h25, 0, 1, 0, 3'd1, 10'd0, 3'b000);
    cyc(1, 8'h25, 0, 1, 0, 3'd2, OPF_OK, 3'b000);
    cyc(1, 8'h25, 0, 1, 0, 3'd3, 10'd0, 3'b000);
    cyc(1, 8'h25, 0, 1, 0, 3'd4, MR | WE, 3'b000);

    // ADD with one stalled MEM cycle
    cyc(1, 8'h31, 0, 1, 0, 3'd0, FETCH_OK, 3'b000);
    cyc(1, 8'h31, 0, 1, 0, 3'd1, 10'd0, 3'b000);
    cyc(1, 8'h31, 0, 1, 0, 3'd2, OPF_OK, 3'b000);
    cyc(1, 8'h31, 0, 1, 0, 3'd3, 10'd0, 3'b000);
    cyc(1, 8'h31, 0, 0, 0, 3'd4, MR, 3'b000);
    cyc(1, 8'h31, 0, 1, 0, 3'd4, MR | AL, 3'b001);

    // SUB with a stalled OPFETCH cycle
    cyc(1, 8'h42, 0, 1, 0, 3'd0, FETCH_OK, 3'b000);
    cyc(1, 8'h42, 0, 1, 0, 3'd1, 10'd0, 3'b000);
    cyc(1, 8'h42, 0, 0, 0, 3'd2, FETCH_WT, 3'b000);
    cyc(1, 8'h42, 0, 1, 0, 3'd2, OPF_OK, 3'b000);
    cyc(1, 8'h42, 0, 1, 0, 3'd3, 10'd0, 3'b000);
    cyc(1, 8'h42, 0, 1, 0, 3'd4, MR | AL, 3'b010);

    // JZ taken, JZ not taken, JMP
    cyc(1, 8'h60, 1, 1, 0, 3'd0, FETCH_OK, 3'b000);
    cyc(1, 8'h60, 1, 1, 0, 3'd1, 10'd0, 3'b000);
    cyc(1, 8'h60, 1, 1, 0, 3'd2, OPF_OK, 3'b000);
    cyc(1, 8'h60, 1, 1, 0, 3'd3, PL, 3'b000);
    cyc(1, 8'h60, 0, 1, 0, 3'd0, FETCH_OK, 3'b000);
    cyc(1, 8'h60, 0, 1, 0, 3'd1, 10'd0, 3'b000);
    cyc(1, 8'h60, 0, 1, 0, 3'd2, OPF_OK, 3'b000);
    cyc(1, 8'h60, 0, 1, 0, 3'd3, 10'd0, 3'b000);
    cyc(1, 8'h50, 0, 1, 0, 3'd0, FETCH_OK, 3'b000);
    cyc(1, 8'h50, 0, 1, 0, 3'd1, 10'd0, 3'b000);
    cyc(1, 8'h50, 0, 1, 0, 3'd2, OPF_OK, 3'b000);
    cyc(1, 8'h50, 0, 1, 0, 3'd3, PL, 3'b000);

    // Illegal opcode -> FAULT; run ignored
    cyc(1, 8'h9A, 0, 1, 0, 3'd0, FETCH_OK, 3'b000);
    cyc(1, 8'h9A, 0, 1, 0, 3'd1, 10'd0, 3'b000);
    cyc(1, 8'h9A, 0, 1, 1, 3'd6, FT, 3'b000);
    cyc(1, 8'h9A, 0, 1, 0, 3'd6, FT, 3'b000);
    cyc(1, 8'h9A, 0, 1, 0, 3'd6, FT, 3'b000);

    // Reset out of FAULT, then HALT for 10 cycles and resume
    cyc(0, 8'hF0, 0, 1, 0, 3'd7, 10'd0, 3'b000);
    cyc(1, 8'hF0, 0, 1, 0, 3'd7, 10'd0, 3'b000);
    cyc(1, 8'hF0, 0, 1, 0, 3'd0, FETCH_OK, 3'b000);
    cyc(1, 8'hF0, 0, 1, 0, 3'd1, 10'd0, 3'b000);
    for (int i = 0; i < 10; i++)
      cyc(1, 8'hF0, 0, 1, 0, 3'd5, HL, 3'b000);
    cyc(1, 8'hF0, 0, 1, 1, 3'd5, HL, 3'b000);
    cyc(1, 8'h00, 0, 1, 0, 3'd0, FETCH_OK, 3'b000);
    cyc(1, 8'h00, 0, 1, 0, 3'd1, 10'd0, 3'b000);

    // FETCH timeout: 15 stalled cycles, then FAULT, run ignored
    for (int i = 0; i < 15; i++)
      cyc(1, 8'h00, 0, 0, 0, 3'd0, FETCH_WT, 3'b000);
    cyc(1, 8'h00, 0, 0, 1, 3'd6, FT, 3'b000);
    cyc(1, 8'h00, 0, 0, 0, 3'd6, FT, 3'b000);

    // mem_ready on the timeout cycle completes the access
    cyc(0, 8'h00, 0, 1, 0, 3'd7, 10'd0, 3'b000);
    cyc(1, 8'h00, 0, 1, 0, 3'd7, 10'd0, 3'b000);
    for (int i = 0; i < 14; i++)
      cyc(1, 8'h00, 0, 0, 0, 3'd0, FETCH_WT, 3'b000);
    cyc(1, 8'h00, 0, 1, 0, 3'd0, FETCH_OK, 3'b000);
    cyc(1, 8'h00, 0, 1, 0, 3'd1, 10'd0, 3'b000);

    // Reset asserted while MEM is stalled drops everything at once
    cyc(1, 8'h13, 0, 1, 0, 3'd0, FETCH_OK, 3'b000);
    cyc(1, 8'h13, 0, 1, 0, 3'd1, 10'd0, 3'b000);
    cyc(1, 8'h13, 0, 1, 0, 3'd2, OPF_OK, 3'b000);
    cyc(1, 8'h13, 0, 1, 0, 3'd3, 10'd0, 3'b000);
    cyc(1, 8'h13, 0, 0, 0, 3'd4, MR, 3'b000);
    cyc(0, 8'h13, 0, 0, 0, 3'd7, 10'd0, 3'b000);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
